imem_fetch_responder: RTL

Instruction-memory side of the fetch handshake. The control FSM requests an instruction at the current PC. This block latches the request, checks the address, and reads a synchronous single-port instruction RAM with a configurable number of wait cycles. It then returns the instruction word and an error flag with a one-cycle acknowledge, which the control FSM uses to write the fetch/decode register and advance the PC.

---
 rtl/imem_fetch_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_responder
//  Description : Instruction-memory responder for the fetch handshake. Latches
//                the request, checks the address and reads a synchronous RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_responder #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          MEM_ADDR_WIDTH = 10,
    parameter int          WAIT_CYCLES    = 1,
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      fetch_req,
    input  logic [ADDR_WIDTH-1:0]     fetch_addr,
    output logic                      fetch_ack,
    output logic [31:0]               fetch_instr,
    output logic                      fetch_err,
    output logic                      busy,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_rden,
    input  logic [31:0]               mem_q
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ISSUE   = 3'd1;
    localparam logic [2:0] c_WAIT    = 3'd2;
    localparam logic [2:0] c_RESP    = 3'd3;
    localparam logic [2:0] c_RELEASE = 3'd4;

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [3:0]                r_wait_cnt;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]               r_instr;
    logic                      r_err;

    logic w_misaligned;
    logic w_out_of_range;
    logic w_addr_err;
    logic w_accept_ok;
    logic w_accept_err;
    logic w_wait_done;

    assign w_misaligned = |fetch_addr[1:0];

    // Any address bit above the RAM word range flags an out-of-range fetch.
    generate
        if (ADDR_WIDTH > MEM_ADDR_WIDTH + 2) begin : g_range_chk
            assign w_out_of_range = |fetch_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
        end else begin : g_no_range_chk
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_addr_err   = w_misaligned | w_out_of_range;
    assign w_accept_ok  = (r_state == c_IDLE) && fetch_req && !w_addr_err;
    assign w_accept_err = (r_state == c_IDLE) && fetch_req &&  w_addr_err;
    assign w_wait_done  = (r_state == c_WAIT) && (r_wait_cnt <= 4'd1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (fetch_req) begin
                    w_state_nxt = w_addr_err ? c_RESP : c_ISSUE;
                end
            end
            c_ISSUE: begin
                w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                if (r_wait_cnt <= 4'd1) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                w_state_nxt = fetch_req ? c_RELEASE : c_IDLE;
            end
            c_RELEASE: begin
                if (!fetch_req) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Moore outputs
    always_comb begin
        busy      = 1'b0;
        fetch_ack = 1'b0;
        mem_rden  = 1'b0;
        case (r_state)
            c_ISSUE: begin
                busy     = 1'b1;
                mem_rden = 1'b1;
            end
            c_WAIT: begin
                busy = 1'b1;
            end
            c_RESP: begin
                busy      = 1'b1;
                fetch_ack = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                fetch_ack = 1'b0;
                mem_rden  = 1'b0;
            end
        endcase
    end

    // Datapath: latched word address, wait counter and response registers.
    // The RAM address is captured at accept so it is stable through ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr <= '0;
            r_wait_cnt <= 4'd0;
            r_instr    <= RESET_INSTR;
            r_err      <= 1'b0;
        end else begin
            if (w_accept_ok) begin
                r_mem_addr <= fetch_addr[MEM_ADDR_WIDTH+1:2];
            end

            if (r_state == c_ISSUE) begin
                r_wait_cnt <= c_WAIT_LOAD;
            end else if ((r_state == c_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            if (w_accept_err) begin
                r_instr <= RESET_INSTR;
                r_err   <= 1'b1;
            end else if (w_wait_done) begin
                r_instr <= mem_q;
                r_err   <= 1'b0;
            end
        end
    end

    assign mem_addr    = r_mem_addr;
    assign fetch_instr = r_instr;
    assign fetch_err   = r_err;

endmodule
`default_nettype wire
